// File: rtl/encoder_pkg.sv
// Shared definitions for the sequential request encoder.
//   DEF_N / DEF_W : default number of request lines and index width
//   state_t       : output-stage state (IDLE = nothing offered, HOLD = index offered)
//   RR_FIXED / RR_ROUND : service-order selector values
package encoder_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = $clog2(DEF_N);

    localparam int RR_FIXED = 0;   // lowest index first
    localparam int RR_ROUND = 1;   // round-robin, starting after the last grant

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/encoder_4_2_seq_prio_find.sv
// Wrapping priority search (purely combinational).
//   vec   : candidate vector
//   start : first position to examine; the scan continues upward and wraps
//   found : at least one bit of vec is set
//   idx   : first set bit at or after start (modulo N); 0 when nothing found
module prio_find #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            int pos;
            pos = int'(start) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && vec[pos]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/encoder_4_2_seq.sv
// Sequential request encoder: collects event bits into a sticky pending set
// and offers one binary index per event on a valid/ready output.
//   clk, rst  : clock and asynchronous active-high reset
//   d_in      : event vector, sampled when d_valid = 1
//   out_idx   : index currently offered; out_valid qualifies it
//   out_ready : consumer takes out_idx on this edge
//   pending   : events captured but not yet loaded into out_idx
//   drop      : one-cycle pulse, an arriving bit collided with a pending one
module encoder_4_2_seq
    import encoder_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = $clog2(N),
    parameter int RR = RR_FIXED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d_in,
    input  logic         d_valid,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         drop
);

    state_t       state_reg, state_next;
    logic [W-1:0] out_idx_reg, out_idx_next;
    logic [W-1:0] last_reg, last_next;
    logic [N-1:0] pending_reg, pending_next;
    logic         drop_reg, drop_next;

    logic [N-1:0] arr;
    logic [N-1:0] cand;
    logic [N-1:0] load_mask;
    logic [W-1:0] start;
    logic [W-1:0] sel_idx;
    logic         found;
    logic         load;

    assign arr  = d_valid ? d_in : '0;
    // New arrivals join the candidate set in the same cycle so a lone event
    // is offered one edge after it arrives.
    assign cand = pending_reg | arr;

    // Round-robin search begins just after the last grant; fixed priority
    // always begins at index 0.
    always_comb begin
        start = '0;
        if (RR == RR_ROUND) begin
            start = (last_reg == W'(N - 1)) ? '0 : last_reg + W'(1);
        end
    end

    prio_find #(
        .N(N),
        .W(W)
    ) u_find (
        .vec  (cand),
        .start(start),
        .found(found),
        .idx  (sel_idx)
    );

    assign load_mask = N'(1) << sel_idx;

    always_comb begin
        state_next   = state_reg;
        out_idx_next = out_idx_reg;
        last_next    = last_reg;
        pending_next = cand;
        load         = 1'b0;

        case (state_reg)
            IDLE: begin
                load = found;
            end
            HOLD: begin
                if (out_ready) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                // Not ready: out_idx stays put and arrivals simply merge.
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            state_next   = HOLD;
            out_idx_next = sel_idx;
            last_next    = sel_idx;
            // The loaded bit leaves the pending set even if it also arrived
            // this cycle: the arrival is the event being served.
            pending_next = cand & ~load_mask;
        end

        // A pending bit hit again is a lost event, except the bit being
        // loaded right now, whose arrival is absorbed by the load.
        drop_next = |(arr & pending_reg & ~(load ? load_mask : '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            out_idx_reg <= '0;
            last_reg    <= W'(N - 1);
            pending_reg <= '0;
            drop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            out_idx_reg <= out_idx_next;
            last_reg    <= last_next;
            pending_reg <= pending_next;
            drop_reg    <= drop_next;
        end
    end

    assign out_idx   = out_idx_reg;
    assign out_valid = (state_reg == HOLD);
    assign pending   = pending_reg;
    assign drop      = drop_reg;

endmodule

// File: doc/encoder_4_2_seq.md
Name: encoder_4_2_seq

Overview:
Sequential request encoder, the encode-side counterpart of the team's 2-to-4 decoder. It accepts one-hot or multi-hot event vectors, holds them in a sticky pending register, and emits one binary index per served event on a valid/ready output. It sits between event sources, for example decoded strobes, and a consumer that accepts one index per cycle. Lowest-index-first or round-robin service is selected by parameter.

Parameters:
N, 4, number of request lines; legal range 2..16.
W, $clog2(N) (2 by default), width of the output index.
RR, 0, selects the service order: 0 means fixed priority with the lowest index first; 1 means round-robin starting after the last granted index.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
d_in  in  N  event vector; one bit per request line.
d_valid  in  1  d_in is sampled only when this is 1.
out_idx  out  W  encoded index of the event currently offered.
out_valid  out  1  out_idx holds a valid served event.
out_ready  in  1  consumer accepts out_idx this cycle.
pending  out  N  events captured but not yet loaded into the output.
drop  out  1  one-cycle pulse: an arriving event bit was already pending and was merged (lost).

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - out_idx=0, out_valid=0, pending=0, drop=0.
  - Round-robin pointer last=N-1, so the first RR search starts at index 0.
- Arrivals: arr = d_valid ? d_in : 0.
  - Candidate set cand = pending | arr, computed combinationally, so a new event can be served with 1-cycle latency.
- Two states:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
- IDLE transitions:
  - If cand!=0, select index s from cand. Next cycle: out_idx=s, out_valid=1, go to HOLD, pending = cand with bit s cleared.
  - If cand==0, stay in IDLE.
- HOLD with out_ready=0:
  - out_idx and out_valid are held stable.
  - pending = pending | arr; nothing is selected.
- HOLD with out_ready=1 (transfer completes this cycle):
  - If cand!=0: load the next s in the same edge. out_valid stays 1, giving a throughput of 1 index per cycle.
  - Otherwise: go to IDLE and drop out_valid. out_idx keeps its last value.
- Selection rule:
  - RR=0: s is the lowest set bit of cand.
  - RR=1: s is the first set bit scanning last+1, last+2, ... mod N. On every load, last=s.
- Simultaneous clear and set: if bit s is cleared by the load while arr[s]=1 in the same cycle, arr[s] is treated as part of cand. It is consumed by this load, with no drop and no re-pend.
- drop:
  - Registered, asserted the cycle after an edge where arr & pending !=0.
  - Bits in flight in out_idx are not pending, so a re-arrival of the held index is accepted as a new pending event.
- d_in=0 with d_valid=1 is legal and has no effect.
- out_idx never changes while out_valid=1 and out_ready=0.

Decomposition:
- Shared package encoder_pkg holds:
  - default N/W constants.
  - state enum {IDLE, HOLD}.
  - localparam RR_FIXED=0, RR_ROUND=1.
- One combinational sub-module, prio_find:
  - Inputs: vector [N-1:0] and start index [W-1:0].
  - Outputs: found and idx[W-1:0] (first set bit at or after start, wrapping).
  - RR=0 ties start to 0.
  - The top module instantiates it once.

Test Plan:
1. Drive traffic, assert rst for 1 cycle mid-HOLD -> out_valid=0, out_idx=0, pending=0, drop=0 immediately (asynchronous); after release, the first RR grant is idx 0.
2. RR=0, d_in=4'b0100 for 1 cycle with d_valid=1, out_ready=1 -> next cycle out_valid=1, out_idx=2; the following cycle out_valid=0, pending=0.
3. RR=0, d_in=4'b1011 for 1 cycle, out_ready=1 -> out_idx=0,1,3 on three consecutive cycles with out_valid continuously 1; pending goes 1010, 1000, 0000.
4. RR=0, d_in=4'b0011, out_ready=0 -> out_idx=0 held for 5 cycles; pending=0010. Then d_in=4'b0010 -> drop=1 for one cycle and pending unchanged. Raise out_ready -> out_idx=1, then out_valid=0.
5. RR=1, after reset d_in=4'b0010 -> idx 1. Then d_in=4'b0011 -> idx 0 first (search starts at 2, wraps), then idx 1.
6. HOLD with out_idx=0, out_ready=1, d_in=4'b0101 in the same cycle (RR=0) -> next out_idx=0 with no drop, then out_idx=2, then IDLE.
